classify_scheduler: RTL and testbench

- Sequences one inference of the systolic classifier per completed voxel window.
- Accepts a frame-ready pulse and bank index from the voxel binner.
- Streams that bank's feature words from the double-buffered feature RAM into the array as an unbroken feature_valid burst.
- Waits for the array result with a watchdog, applies a confidence threshold, and emits one gesture event.

---
 rtl/classify_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_classify_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/classify_scheduler.sv
// Sequences one classifier inference per completed voxel window: streams the feature bank into
// the systolic array, waits for its result under a watchdog, and emits one gesture event.
module classify_scheduler #(
    parameter int unsigned NUM_CELLS       = 1024,
    parameter int unsigned PARALLEL_INPUTS = 4,
    parameter int unsigned VALUE_BITS      = 6,
    parameter int unsigned NUM_CLASSES     = 4,
    parameter int unsigned ACC_BITS        = 24,
    parameter int          SCORE_THRESH    = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    localparam int unsigned NUM_WORDS = (NUM_CELLS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS,
    localparam int unsigned WA        = $clog2(NUM_WORDS),
    localparam int unsigned FW        = PARALLEL_INPUTS * VALUE_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sched_en,
    input  logic                          frame_ready,
    input  logic                          frame_bank,
    output logic                          fm_rd_en,
    output logic                          fm_rd_bank,
    output logic [WA-1:0]                 fm_rd_addr,
    input  logic [FW-1:0]                 fm_rd_data,
    output logic                          arr_start,
    output logic [FW-1:0]                 arr_feature_in,
    output logic                          arr_feature_valid,
    input  logic                          arr_result_valid,
    input  logic [1:0]                    arr_best_class,
    input  logic [NUM_CLASSES*ACC_BITS-1:0] arr_scores_flat,
    output logic                          gesture_valid,
    output logic [1:0]                    gesture_class,
    output logic                          gesture_confident,
    output logic [ACC_BITS-1:0]           gesture_score,
    output logic                          busy,
    output logic [7:0]                    drop_cnt,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ACC_BITS-1:0] Thresh = ACC_BITS'(SCORE_THRESH);

    typedef enum logic [2:0] {StIdle, StStart, StStream, StWait, StReport} state_e;

    state_e              state_q, state_d;
    logic                bank_q, bank_d;
    logic                pend_q, pend_d;
    logic                pend_bank_q, pend_bank_d;
    logic [WA-1:0]       word_q, word_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [7:0]          drop_q, drop_d;
    logic                tmo_q, tmo_d;
    logic [1:0]          cls_q, cls_d;
    logic [ACC_BITS-1:0] score_q, score_d;
    logic                conf_q, conf_d;
    logic [ACC_BITS-1:0] score_sel;
    logic                accept, last_word, launch_direct;

    assign accept        = frame_ready & sched_en;
    assign last_word     = (word_q == WA'(NUM_WORDS - 1));
    assign launch_direct = (state_q == StIdle) && !pend_q;

    always_comb begin
        score_sel = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (arr_best_class == c[1:0]) score_sel = arr_scores_flat[c*ACC_BITS +: ACC_BITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bank_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            word_q      <= '0;
            wd_q        <= '0;
            drop_q      <= '0;
            tmo_q       <= 1'b0;
            cls_q       <= '0;
            score_q     <= '0;
            conf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            word_q      <= word_d;
            wd_q        <= wd_d;
            drop_q      <= drop_d;
            tmo_q       <= tmo_d;
            cls_q       <= cls_d;
            score_q     <= score_d;
            conf_q      <= conf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        word_d      = word_q;
        wd_d        = wd_q;
        drop_d      = drop_q;
        tmo_d       = tmo_q;
        cls_d       = cls_q;
        score_d     = score_q;
        conf_d      = conf_q;
        if (err_clr) begin
            tmo_d  = 1'b0;
            drop_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                // A queued request always goes ahead of a fresh one.
                if (pend_q) begin
                    bank_d  = pend_bank_q;
                    pend_d  = 1'b0;
                    state_d = StStart;
                end else if (accept) begin
                    bank_d  = frame_bank;
                    state_d = StStart;
                end
            end
            StStart: begin
                word_d  = '0;
                state_d = StStream;
            end
            StStream: begin
                if (last_word) begin
                    wd_d    = '0;
                    state_d = StWait;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            StWait: begin
                if (arr_result_valid) begin
                    cls_d   = arr_best_class;
                    score_d = score_sel;
                    conf_d  = ($signed(score_sel) >= $signed(Thresh));
                    state_d = StReport;
                end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Requests that cannot launch now park in the one-deep slot; newest bank wins.
        if (accept && !launch_direct) begin
            pend_d      = 1'b1;
            pend_bank_d = frame_bank;
            if (pend_q && state_q != StIdle && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        fm_rd_en          = 1'b0;
        fm_rd_addr        = '0;
        arr_start         = 1'b0;
        arr_feature_valid = 1'b0;
        arr_feature_in    = '0;
        gesture_valid     = 1'b0;
        unique case (state_q)
            StStart: begin
                arr_start = 1'b1;
                fm_rd_en  = 1'b1;
            end
            StStream: begin
                arr_feature_valid = 1'b1;
                arr_feature_in    = fm_rd_data;
                if (!last_word) begin
                    fm_rd_en   = 1'b1;
                    fm_rd_addr = word_q + 1'b1;
                end
            end
            StReport: gesture_valid = 1'b1;
            default: ;
        endcase
    end

    assign fm_rd_bank        = bank_q;
    assign busy              = (state_q != StIdle) | pend_q;
    assign drop_cnt          = drop_q;
    assign timeout_err       = tmo_q;
    assign gesture_class     = cls_q;
    assign gesture_score     = score_q;
    assign gesture_confident = conf_q;

endmodule

// File: tb/tb_classify_scheduler.sv
// Randomized self-checking bench for classify_scheduler with a feature RAM model, an array model
// and a behavioural view of the expected stream, gesture and flag outcomes.
module tb_classify_scheduler;

    localparam int NUM_WORDS = 256;
    localparam int THRESH    = 0;

    logic        clk = 1'b0, rst_n = 1'b0, sched_en = 1'b0, frame_ready = 1'b0, frame_bank = 1'b0;
    logic        err_clr = 1'b0;
    logic        fm_rd_en, fm_rd_bank, arr_start, arr_feature_valid, gesture_valid;
    logic        gesture_confident, busy, timeout_err;
    logic [7:0]  fm_rd_addr, drop_cnt;
    logic [23:0] fm_rd_data, arr_feature_in, gesture_score;
    logic [1:0]  gesture_class;
    logic        arr_result_valid = 1'b0;
    logic [1:0]  best_cls = 2'd0;
    logic [95:0] arr_scores_flat;
    int          score_tbl[4];
    bit          withhold = 1'b0;
    logic        exp_bank = 1'b0;

    int cyc = 0, t0 = 0, n_checks = 0, n_fail = 0;
    int mon_start = 0, mon_starts = 0, mon_fv = 0, mon_first = 0, mon_last = 0;
    int mon_derr = 0, mon_berr = 0, mon_gv = 0, mon_gv_cyc = 0;
    int am_words = 0, am_cnt = 0;

    assign arr_scores_flat = {score_tbl[3][23:0], score_tbl[2][23:0],
                              score_tbl[1][23:0], score_tbl[0][23:0]};

    classify_scheduler dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .frame_ready(frame_ready),
        .frame_bank(frame_bank), .fm_rd_en(fm_rd_en), .fm_rd_bank(fm_rd_bank),
        .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data), .arr_start(arr_start),
        .arr_feature_in(arr_feature_in), .arr_feature_valid(arr_feature_valid),
        .arr_result_valid(arr_result_valid), .arr_best_class(best_cls),
        .arr_scores_flat(arr_scores_flat), .gesture_valid(gesture_valid),
        .gesture_class(gesture_class), .gesture_confident(gesture_confident),
        .gesture_score(gesture_score), .busy(busy), .drop_cnt(drop_cnt),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] ram_word(input logic bank, input int n);
        logic [5:0] v;
        v = bank ? 6'(n % 64) : 6'((n * 5 + 17) % 64);
        return {v, v, v, v};
    endfunction

    always @(posedge clk) if (fm_rd_en) fm_rd_data <= ram_word(fm_rd_bank, int'(fm_rd_addr));

    // Array model: result three cycles after the last feature word unless withheld.
    always @(negedge clk) begin
        if (!rst_n) begin
            am_words = 0;
            am_cnt = 0;
            arr_result_valid <= 1'b0;
        end else begin
            arr_result_valid <= 1'b0;
            if (arr_start) am_words = 0;
            if (arr_feature_valid) begin
                am_words++;
                if (am_words == NUM_WORDS) am_cnt = 3;
            end else if (am_cnt > 0) begin
                am_cnt--;
                if (am_cnt == 0 && !withhold) arr_result_valid <= 1'b1;
            end
        end
    end

    // Stream observer: logs each inference against the expected bank contents.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arr_start) begin
                mon_start = cyc; mon_starts++; mon_fv = 0; mon_derr = 0; mon_berr = 0;
                if (fm_rd_bank !== exp_bank) mon_berr++;
            end
            if (arr_feature_valid) begin
                if (mon_fv == 0) mon_first = cyc;
                mon_last = cyc;
                if (arr_feature_in !== ram_word(exp_bank, mon_fv)) mon_derr++;
                if (fm_rd_bank !== exp_bank) mon_berr++;
                mon_fv++;
            end
            if (gesture_valid) begin
                mon_gv++;
                mon_gv_cyc = cyc;
            end
        end
    end

    task automatic pulse(input logic bank);
        @(posedge clk); #1;
        frame_ready = 1'b1; frame_bank = bank; t0 = cyc;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic set_scores(input int s0, input int s1, input int s2, input int s3,
                              input logic [1:0] b);
        score_tbl[0] = s0; score_tbl[1] = s1; score_tbl[2] = s2; score_tbl[3] = s3;
        best_cls = b;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, gesture_valid, arr_start, fm_rd_en, arr_feature_valid, timeout_err,
             gesture_confident, fm_rd_bank} !== 8'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {busy, gesture_valid,
                arr_start, fm_rd_en, arr_feature_valid, timeout_err, gesture_confident, fm_rd_bank});
        end
        n_checks++;
        if ({drop_cnt, gesture_class, gesture_score, fm_rd_addr, arr_feature_in} !== 66'h0) begin
            n_fail++; $display("FAIL reset_data: drop %0d cls %0d score %0d addr %0d expected all 0",
                drop_cnt, gesture_class, gesture_score, fm_rd_addr);
        end
        @(posedge clk); #1; rst_n = 1'b1; sched_en = 1'b1;
    endtask

    task automatic test_single_frame;
        int gb; bit ok;
        set_scores(-5, 100, 7, 3, 2'd1); exp_bank = 1'b1; gb = mon_gv;
        pulse(1'b1);
        wait_idle(400, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %0d expected 1", ok); end
        n_checks++; if (mon_start - t0 !== 1) begin n_fail++; $display("FAIL single_start: got %0d expected 1", mon_start - t0); end
        n_checks++; if (mon_first - t0 !== 2) begin n_fail++; $display("FAIL single_first_fv: got %0d expected 2", mon_first - t0); end
        n_checks++; if (mon_fv !== NUM_WORDS) begin n_fail++; $display("FAIL single_fv_cnt: got %0d expected %0d", mon_fv, NUM_WORDS); end
        n_checks++; if (mon_last - mon_first + 1 !== NUM_WORDS) begin n_fail++; $display("FAIL single_contig: got span %0d expected %0d", mon_last - mon_first + 1, NUM_WORDS); end
        n_checks++; if (mon_derr !== 0 || mon_berr !== 0) begin n_fail++; $display("FAIL single_data: got %0d/%0d errors expected 0", mon_derr, mon_berr); end
        n_checks++; if (mon_gv - gb !== 1) begin n_fail++; $display("FAIL single_gv_cnt: got %0d expected 1", mon_gv - gb); end
        n_checks++; if (mon_gv_cyc - t0 !== NUM_WORDS + 5) begin n_fail++; $display("FAIL single_gv_cyc: got %0d expected %0d", mon_gv_cyc - t0, NUM_WORDS + 5); end
        n_checks++; if ({gesture_class, gesture_score, gesture_confident} !== {2'd1, 24'd100, 1'b1}) begin
            n_fail++; $display("FAIL single_gesture: got cls %0d score %0d conf %0d expected 1 100 1", gesture_class, $signed(gesture_score), gesture_confident);
        end
    endtask

    task automatic test_negative_scores;
        bit ok;
        set_scores(-5, -2, -9, -7, 2'd1); exp_bank = 1'b1;
        pulse(1'b1);
        wait_idle(400, ok);
        n_checks++; if (gesture_score !== 24'(-2)) begin n_fail++; $display("FAIL neg_score: got %0d expected -2", $signed(gesture_score)); end
        n_checks++; if (gesture_confident !== 1'b0) begin n_fail++; $display("FAIL neg_conf: got %0d expected 0", gesture_confident); end
    endtask

    task automatic test_pending;
        int gb, sb, busy_low, busy_pulses, exp_drop; bit ok;
        set_scores(1, 2, 300, 4, 2'd2); exp_bank = 1'b0; gb = mon_gv; sb = mon_starts;
        pulse(1'b0);
        repeat (30) @(posedge clk);
        pulse(1'b1);
        repeat (30) @(posedge clk);
        pulse(1'b0);
        busy_pulses = 2;
        exp_drop = busy_pulses - 1;
        busy_low = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (mon_gv - gb >= 2) break;
            if (!busy) busy_low++;
        end
        n_checks++; if (mon_gv - gb !== 2) begin n_fail++; $display("FAIL pend_gv_cnt: got %0d expected 2", mon_gv - gb); end
        n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL pend_busy: got %0d idle cycles expected 0", busy_low); end
        n_checks++; if (drop_cnt !== 8'(exp_drop)) begin n_fail++; $display("FAIL pend_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        n_checks++; if (mon_starts - sb !== 2) begin n_fail++; $display("FAIL pend_starts: got %0d expected 2", mon_starts - sb); end
        n_checks++; if (mon_derr !== 0 || mon_berr !== 0) begin n_fail++; $display("FAIL pend_bank: got %0d/%0d errors expected 0", mon_derr, mon_berr); end
        wait_idle(50, ok);
    endtask

    task automatic test_timeout;
        int gb, first_to; bit ok;
        withhold = 1'b1; exp_bank = 1'b1; gb = mon_gv; first_to = -1;
        pulse(1'b1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (timeout_err && first_to < 0) first_to = cyc;
            if (!busy) break;
        end
        n_checks++; if (first_to - t0 !== NUM_WORDS + 2 + 16) begin n_fail++; $display("FAIL to_cycle: got %0d expected %0d", first_to - t0, NUM_WORDS + 18); end
        n_checks++; if (mon_gv - gb !== 0) begin n_fail++; $display("FAIL to_no_gv: got %0d expected 0", mon_gv - gb); end
        withhold = 1'b0; exp_bank = 1'b0; gb = mon_gv;
        set_scores(10, 20, 30, 40, 2'd3);
        pulse(1'b0);
        wait_idle(400, ok);
        n_checks++; if (mon_gv - gb !== 1) begin n_fail++; $display("FAIL to_recover: got %0d expected 1", mon_gv - gb); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0d expected 1", timeout_err); end
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        n_checks++; if ({timeout_err, drop_cnt} !== 9'h0) begin n_fail++; $display("FAIL to_clear: got err %0d drop %0d expected 0 0", timeout_err, drop_cnt); end
    endtask

    task automatic test_reset_mid;
        int gb; bit ok;
        exp_bank = 1'b1; gb = mon_gv;
        pulse(1'b1);
        repeat (101) @(posedge clk); #1;
        n_checks++; if (mon_fv !== 100) begin n_fail++; $display("FAIL rmid_word: got %0d expected 100", mon_fv); end
        rst_n = 1'b0; #1;
        n_checks++;
        if ({busy, arr_feature_valid, fm_rd_en, fm_rd_bank, fm_rd_addr, arr_feature_in} !== 36'h0) begin
            n_fail++; $display("FAIL rmid_async: got busy %0d fv %0d rd %0d addr %0d expected 0", busy, arr_feature_valid, fm_rd_en, fm_rd_addr);
        end
        repeat (3) @(posedge clk); #1; rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++; if (mon_gv - gb !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got gv %0d busy %0d expected 0 0", mon_gv - gb, busy); end
        set_scores(0, 0, 5, 0, 2'd2);
        pulse(1'b1);
        wait_idle(400, ok);
        n_checks++; if (mon_gv_cyc - t0 !== NUM_WORDS + 5 || mon_gv - gb !== 1) begin n_fail++; $display("FAIL rmid_fresh: got cycle %0d count %0d expected %0d 1", mon_gv_cyc - t0, mon_gv - gb, NUM_WORDS + 5); end
    endtask

    task automatic test_sched_en;
        int gb, sb; bit ok;
        sched_en = 1'b0; gb = mon_gv; sb = mon_starts;
        pulse(1'b1);
        repeat (10) @(negedge clk);
        n_checks++; if (mon_starts - sb !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL sen_ignore: got starts %0d busy %0d expected 0 0", mon_starts - sb, busy); end
        sched_en = 1'b1; exp_bank = 1'b0;
        pulse(1'b0);
        repeat (50) @(posedge clk); #1; sched_en = 1'b0;
        wait_idle(400, ok);
        n_checks++; if (mon_gv - gb !== 1 || mon_fv !== NUM_WORDS) begin n_fail++; $display("FAIL sen_midstream: got gv %0d words %0d expected 1 %0d", mon_gv - gb, mon_fv, NUM_WORDS); end
        sched_en = 1'b1;
    endtask

    task automatic test_random;
        int exp_sc; logic b; logic [1:0] bc; bit ok;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) score_tbl[c] = int'($urandom_range(2000)) - 1000;
            bc = 2'($urandom_range(3));
            b  = 1'($urandom_range(1));
            if (i == 0) score_tbl[bc] = THRESH;
            if (i == 1) score_tbl[bc] = THRESH - 1;
            best_cls = bc; exp_bank = b; exp_sc = score_tbl[bc];
            pulse(b);
            wait_idle(400, ok);
            n_checks++; if (gesture_class !== bc) begin n_fail++; $display("FAIL rnd_cls[%0d]: got %0d expected %0d", i, gesture_class, bc); end
            n_checks++; if (gesture_score !== 24'(exp_sc)) begin n_fail++; $display("FAIL rnd_score[%0d]: got %0d expected %0d", i, $signed(gesture_score), exp_sc); end
            n_checks++; if (gesture_confident !== (exp_sc >= THRESH)) begin n_fail++; $display("FAIL rnd_conf[%0d]: got %0d expected %0d", i, gesture_confident, exp_sc >= THRESH); end
            n_checks++; if (mon_derr !== 0 || mon_berr !== 0) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0d/%0d errors expected 0", i, mon_derr, mon_berr); end
            n_checks++; if (mon_gv_cyc - t0 !== NUM_WORDS + 5) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, mon_gv_cyc - t0, NUM_WORDS + 5); end
        end
    endtask

    initial begin
        set_scores(0, 0, 0, 0, 2'd0);
        test_reset();
        test_single_frame();
        test_negative_scores();
        test_pending();
        test_timeout();
        test_reset_mid();
        test_sched_en();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
